// File: rtl/iterative_multiplier_if.sv
// Request/response bundle between the issuing execute stage and the multiplier.
// Handshake: a one-cycle start pulse (qualified by ~flush) launches an operation; result_valid pulses for exactly one cycle when result is fresh.
interface iterative_multiplier_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            flush;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic [XLEN-1:0] result;
    logic            result_valid;
    logic            busy;
    logic            alu_op_done;

    modport master (
        output start, flush, operand_a, operand_b,
        input  result, result_valid, busy, alu_op_done
    );

    modport slave (
        input  start, flush, operand_a, operand_b,
        output result, result_valid, busy, alu_op_done
    );
endinterface

// File: rtl/iterative_multiplier.sv
// Multi-cycle shift-add multiplier producing the low XLEN bits of a*b (RISC-V MUL).
// Optional feature: define MUL_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are all zero.
module iterative_multiplier #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    iterative_multiplier_if.slave  bus,
    output logic [1:0]             dbg_state
);
    localparam int NITER = XLEN / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(NITER + 1);
    localparam logic [CNT_W-1:0] NITER_C = CNT_W'(NITER);

    generate
        if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4) ||
            (XLEN % BITS_PER_CYCLE) != 0) begin : g_bad_cfg
            $error("iterative_multiplier: illegal BITS_PER_CYCLE");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [XLEN-1:0]  mcand_q, mcand_d;
    logic [XLEN-1:0]  mplier_q, mplier_d;
    logic [XLEN-1:0]  acc_q, acc_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             go;
    logic             last_iter;
    logic [XLEN-1:0]  partial;
    logic [XLEN-1:0]  acc_nxt;
    logic [XLEN-1:0]  mplier_nxt;

    assign go = bus.start & ~bus.flush;

    // Partial product of the multiplicand with the low BITS_PER_CYCLE multiplier bits.
    always_comb begin
        partial = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mplier_q[i]) begin
                partial = partial + (mcand_q << i);
            end
        end
    end

    assign acc_nxt    = acc_q + partial;
    assign mplier_nxt = mplier_q >> BITS_PER_CYCLE;

`ifdef MUL_EARLY_EXIT_EN
    assign last_iter = (cnt_q == CNT_W'(1)) || (mplier_nxt == '0);
`else
    assign last_iter = (cnt_q == CNT_W'(1));
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state logic; flush has priority over both completion and a new start.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (go) state_d = BUSY;
            BUSY: begin
                if (bus.flush)     state_d = IDLE;
                else if (last_iter) state_d = DONE;
            end
            DONE: state_d = go ? BUSY : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath updates.
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        if (state_q != BUSY) begin
            if (go) begin
                mcand_d  = bus.operand_a;
                mplier_d = bus.operand_b;
                acc_d    = '0;
                cnt_d    = NITER_C;
            end
        end else if (!bus.flush) begin
            acc_d    = acc_nxt;
            mcand_d  = mcand_q << BITS_PER_CYCLE;
            mplier_d = mplier_nxt;
            cnt_d    = cnt_q - CNT_W'(1);
            if (last_iter) begin
                result_d = acc_nxt;
            end
        end
    end

    // Outputs; alu_op_done drops combinationally in the cycle start is issued.
    always_comb begin
        bus.result       = result_q;
        bus.result_valid = (state_q == DONE);
        bus.busy         = (state_q == BUSY);
        bus.alu_op_done  = !((state_q == BUSY) || go);
        dbg_state        = state_q;
    end
endmodule

// File: tb/tb_iterative_multiplier.sv
// Self-checking bench for iterative_multiplier: vector table, random operands vs. an arithmetic model,
// and hand-written flush / back-to-back / mid-operation reset sequences.
module tb_iterative_multiplier;
    localparam int XLEN  = 32;
    localparam int BPC   = 1;
    localparam int NITER = XLEN / BPC;

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;

    int total;
    int bad;

    iterative_multiplier_if #(.XLEN(XLEN)) mul_if ();

    iterative_multiplier #(
        .XLEN           (XLEN),
        .BITS_PER_CYCLE (BPC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (mul_if.slave),
        .dbg_state (dbg_state)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] exp;
    } vec_t;

    logic [XLEN-1:0] exp_q[$];

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: plain arithmetic on the full product, keep the low word.
    function automatic logic [XLEN-1:0] model_prod(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        logic [2*XLEN-1:0] p;
        p = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
        return p[XLEN-1:0];
    endfunction

    function automatic int model_lat(input logic [XLEN-1:0] b);
`ifdef MUL_EARLY_EXIT_EN
        int msb;
        int l;
        msb = -1;
        for (int i = 0; i < XLEN; i++) if (b[i]) msb = i;
        l = (msb + 1 + BPC - 1) / BPC;
        return (l < 1) ? 1 : l;
`else
        return NITER;
`endif
    endfunction

    // Driver: called at a falling edge; returns at the falling edge where DONE is observed.
    task automatic run_mul(input string name, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        int cnt;
        int viol;
        logic [XLEN-1:0] exp;
        exp_q.push_back(model_prod(a, b));
        mul_if.start     = 1'b1;
        mul_if.operand_a = a;
        mul_if.operand_b = b;
        #1;
        chk({name, ".ado_in_start_cycle"}, XLEN'(mul_if.alu_op_done), '0);
        @(negedge clk);
        mul_if.start     = 1'b0;
        mul_if.operand_a = $urandom;
        mul_if.operand_b = $urandom;
        cnt  = 1;
        viol = 0;
        while (mul_if.result_valid !== 1'b1 && cnt < NITER + 4) begin
            if (mul_if.alu_op_done !== 1'b0 || mul_if.busy !== 1'b1) viol++;
            @(negedge clk);
            cnt++;
        end
        chk({name, ".busy_cycles_ok"}, XLEN'(viol), '0);
        chk({name, ".latency"}, XLEN'(cnt - 1), XLEN'(model_lat(b)));
        exp = exp_q.pop_front();
        chk({name, ".result"}, mul_if.result, exp);
        chk({name, ".ado_in_done"}, XLEN'(mul_if.alu_op_done), XLEN'(1));
    endtask

    task automatic idle_after_done(input string name, input logic [XLEN-1:0] exp_res);
        @(negedge clk);
        chk({name, ".valid_one_cycle"}, XLEN'(mul_if.result_valid), '0);
        chk({name, ".busy_idle"}, XLEN'(mul_if.busy), '0);
        chk({name, ".result_held"}, mul_if.result, exp_res);
    endtask

    initial begin
        vec_t vecs[8];
        logic [XLEN-1:0] prev;
        logic [XLEN-1:0] ra;
        logic [XLEN-1:0] rb;
        int rv_seen;

        vecs[0] = '{a: 32'd7,          b: 32'd6,          exp: 32'd42};
        vecs[1] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  exp: 32'h0000_0001};
        vecs[2] = '{a: 32'd12345,      b: 32'd6789,       exp: 32'd83810205};
        vecs[3] = '{a: 32'h0001_0000,  b: 32'h0001_0000,  exp: 32'h0000_0000};
        vecs[4] = '{a: 32'hDEAD_BEEF,  b: 32'd0,          exp: 32'h0000_0000};
        vecs[5] = '{a: 32'h8000_0000,  b: 32'd3,          exp: 32'h8000_0000};
        vecs[6] = '{a: 32'd3,          b: 32'd2,          exp: 32'd6};
        vecs[7] = '{a: 32'hFFFF_FFFF,  b: 32'd2,          exp: 32'hFFFF_FFFE};

        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        mul_if.start     = 1'b0;
        mul_if.flush     = 1'b0;
        mul_if.operand_a = '0;
        mul_if.operand_b = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        chk("reset.alu_op_done", XLEN'(mul_if.alu_op_done), XLEN'(1));
        chk("reset.busy", XLEN'(mul_if.busy), '0);
        chk("reset.result", mul_if.result, '0);
        chk("reset.result_valid", XLEN'(mul_if.result_valid), '0);

        // Table-driven vectors
        for (int i = 0; i < 8; i++) begin
            run_mul($sformatf("vec%0d", i), vecs[i].a, vecs[i].b);
            chk($sformatf("vec%0d.table_exp", i), mul_if.result, vecs[i].exp);
            idle_after_done($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Randomized operands against the model
        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            run_mul($sformatf("rand%0d", i), ra, rb);
            idle_after_done($sformatf("rand%0d", i), model_prod(ra, rb));
        end

        // start together with flush in IDLE is dropped
        prev = mul_if.result;
        mul_if.start = 1'b1;
        mul_if.flush = 1'b1;
        mul_if.operand_a = 32'd9;
        mul_if.operand_b = 32'd9;
        #1;
        chk("start_flush.ado", XLEN'(mul_if.alu_op_done), XLEN'(1));
        @(negedge clk);
        mul_if.start = 1'b0;
        mul_if.flush = 1'b0;
        chk("start_flush.busy", XLEN'(mul_if.busy), '0);
        chk("start_flush.state", XLEN'(dbg_state), '0);

        // Flush mid-operation: sampled at E10, idle afterwards, result untouched
        prev = mul_if.result;
        mul_if.start     = 1'b1;
        mul_if.operand_a = 32'd5;
`ifdef MUL_EARLY_EXIT_EN
        mul_if.operand_b = 32'h8000_0009;
`else
        mul_if.operand_b = 32'd9;
`endif
        rv_seen = 0;
        @(negedge clk);
        mul_if.start = 1'b0;
        for (int c = 1; c < 10; c++) begin
            if (mul_if.result_valid === 1'b1) rv_seen++;
            @(negedge clk);
        end
        mul_if.flush = 1'b1;
        @(negedge clk);
        mul_if.flush = 1'b0;
        chk("flush.busy", XLEN'(mul_if.busy), '0);
        chk("flush.ado", XLEN'(mul_if.alu_op_done), XLEN'(1));
        chk("flush.result_kept", mul_if.result, prev);
        for (int c = 0; c < NITER + 4; c++) begin
            if (mul_if.result_valid === 1'b1) rv_seen++;
            @(negedge clk);
        end
        chk("flush.no_valid_pulse", XLEN'(rv_seen), '0);
        chk("flush.result_still_kept", mul_if.result, prev);

        // Back-to-back: start issued during DONE
        run_mul("b2b_first", 32'd3, 32'd4);
        chk("b2b_first.valid", XLEN'(mul_if.result_valid), XLEN'(1));
        run_mul("b2b_second", 32'd10, 32'd10);
        idle_after_done("b2b_second", 32'd100);

        // Asynchronous reset in the middle of an operation
        mul_if.start     = 1'b1;
        mul_if.operand_a = 32'h1234_5678;
        mul_if.operand_b = 32'hFFFF_FFFF;
        @(negedge clk);
        mul_if.start = 1'b0;
        repeat (14) @(negedge clk);
        chk("mid_rst.busy_before", XLEN'(mul_if.busy), XLEN'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst.busy", XLEN'(mul_if.busy), '0);
        chk("mid_rst.ado", XLEN'(mul_if.alu_op_done), XLEN'(1));
        chk("mid_rst.result", mul_if.result, '0);
        chk("mid_rst.valid", XLEN'(mul_if.result_valid), '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst.state_idle", XLEN'(dbg_state), '0);

        // Operation after reset still works
        run_mul("post_rst", 32'd3, 32'd2);
        idle_after_done("post_rst", 32'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
